// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters. Grants are round-robin.
// Each requester has a one-entry registered response slot.
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_opcode,
   input  logic [OPW-1:0]   req0_shamt,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_opcode,
   input  logic [OPW-1:0]   req1_shamt,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [WIDTH-1:0] alu_opA,
   output logic [WIDTH-1:0] alu_opB,
   output logic [OPW-1:0]   alu_opcode,
   output logic [OPW-1:0]   alu_shamt,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_ne,
   input  logic             alu_lt,
   input  logic             alu_ovf,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_ne,
   output logic             rsp0_lt,
   output logic             rsp0_ovf,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_ne,
   output logic             rsp1_lt,
   output logic             rsp1_ovf
);

   logic [1:0]       reqValid;
   logic [1:0]       rspReady;
   logic [1:0]       eligible;
   logic [1:0]       grant;
   logic [1:0]       rspValidReg;
   logic [1:0]       rspNeReg;
   logic [1:0]       rspLtReg;
   logic [1:0]       rspOvfReg;
   logic [WIDTH-1:0] rspResultReg [2];
   logic             ptrReg;

   assign reqValid = {req1_valid, req0_valid};
   assign rspReady = {rsp1_ready, rsp0_ready};

   // A full slot that drains this cycle still counts as free.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gSlot
         assign eligible[gi] = reqValid[gi] & (~rspValidReg[gi] | rspReady[gi]);

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               rspValidReg[gi]  <= 1'b0;
               rspResultReg[gi] <= '0;
               rspNeReg[gi]     <= 1'b0;
               rspLtReg[gi]     <= 1'b0;
               rspOvfReg[gi]    <= 1'b0;
            end else if (grant[gi]) begin
               rspValidReg[gi]  <= 1'b1;
               rspResultReg[gi] <= alu_result;
               rspNeReg[gi]     <= alu_ne;
               rspLtReg[gi]     <= alu_lt;
               rspOvfReg[gi]    <= alu_ovf;
            end else if (rspReady[gi]) begin
               rspValidReg[gi]  <= 1'b0;
            end
         end
      end
   endgenerate

   // ptrReg names the requester that wins when both are eligible.
   assign grant[0] = eligible[0] & (~eligible[1] | ~ptrReg);
   assign grant[1] = eligible[1] & (~eligible[0] |  ptrReg);

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset)         ptrReg <= 1'b0;
      else if (grant[0]) ptrReg <= 1'b1;
      else if (grant[1]) ptrReg <= 1'b0;
   end

   // Idle ALU inputs are forced to zero so they do not toggle.
   always_comb begin
      alu_opA    = '0;
      alu_opB    = '0;
      alu_opcode = '0;
      alu_shamt  = '0;
      if (grant[0]) begin
         alu_opA    = req0_a;
         alu_opB    = req0_b;
         alu_opcode = req0_opcode;
         alu_shamt  = req0_shamt;
      end else if (grant[1]) begin
         alu_opA    = req1_a;
         alu_opB    = req1_b;
         alu_opcode = req1_opcode;
         alu_shamt  = req1_shamt;
      end
   end

   assign rsp0_valid  = rspValidReg[0];
   assign rsp0_result = rspResultReg[0];
   assign rsp0_ne     = rspNeReg[0];
   assign rsp0_lt     = rspLtReg[0];
   assign rsp0_ovf    = rspOvfReg[0];
   assign rsp1_valid  = rspValidReg[1];
   assign rsp1_result = rspResultReg[1];
   assign rsp1_ne     = rspNeReg[1];
   assign rsp1_lt     = rspLtReg[1];
   assign rsp1_ovf    = rspOvfReg[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small ALU model attached.
// ALU model opcodes: 0 = add, 1 = sub, 2 = and.
module tb_alu_share_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [4:0]  req0_opcode = '0, req0_shamt = '0, req1_opcode = '0, req1_shamt = '0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [31:0] alu_opA, alu_opB, alu_result;
   logic [4:0]  alu_opcode, alu_shamt;
   logic        alu_ne, alu_lt, alu_ovf;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] rsp0_result, rsp1_result;
   logic        rsp0_ne, rsp0_lt, rsp0_ovf, rsp1_ne, rsp1_lt, rsp1_ovf;

   int nAsserts = 0;
   int nFails   = 0;

   always #5 clock = ~clock;

   alu_share_arbiter #(.WIDTH(32), .OPW(5)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_shamt(req0_shamt), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_shamt(req1_shamt), .req1_a(req1_a), .req1_b(req1_b),
      .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode), .alu_shamt(alu_shamt),
      .alu_result(alu_result), .alu_ne(alu_ne), .alu_lt(alu_lt), .alu_ovf(alu_ovf),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .rsp0_ne(rsp0_ne), .rsp0_lt(rsp0_lt), .rsp0_ovf(rsp0_ovf),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .rsp1_ne(rsp1_ne), .rsp1_lt(rsp1_lt), .rsp1_ovf(rsp1_ovf)
   );

   always_comb begin
      alu_result = alu_opA ^ alu_opB;
      alu_ovf    = 1'b0;
      case (alu_opcode)
         5'd0: begin
            alu_result = alu_opA + alu_opB;
            alu_ovf    = (alu_opA[31] == alu_opB[31]) && (alu_result[31] != alu_opA[31]);
         end
         5'd1: begin
            alu_result = alu_opA - alu_opB;
            alu_ovf    = (alu_opA[31] != alu_opB[31]) && (alu_result[31] != alu_opA[31]);
         end
         5'd2: alu_result = alu_opA & alu_opB;
         default: ;
      endcase
      alu_ne = (alu_opA != alu_opB);
      alu_lt = ($signed(alu_opA) < $signed(alu_opB));
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic driveStep();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Power-on reset
      @(negedge clock);
      check("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
      check("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
      check("reset_alu_opA", alu_opA, 32'd0);
      driveStep();
      reset = 1'b0;

      // Single op: 5 + 7 on requester 0
      req0_valid = 1'b1; req0_opcode = 5'd0; req0_shamt = 5'd3;
      req0_a = 32'd5; req0_b = 32'd7; rsp0_ready = 1'b1;
      @(negedge clock);
      check("single_req0_ready", 32'(req0_ready), 32'd1);
      check("single_alu_opA", alu_opA, 32'd5);
      check("single_alu_shamt", 32'(alu_shamt), 32'd3);
      check("single_rsp0_valid_n", 32'(rsp0_valid), 32'd0);
      driveStep();
      req0_valid = 1'b0;
      @(negedge clock);
      check("single_rsp0_valid", 32'(rsp0_valid), 32'd1);
      check("single_rsp0_result", rsp0_result, 32'd12);
      check("single_rsp0_ne", 32'(rsp0_ne), 32'd1);
      check("single_rsp0_lt", 32'(rsp0_lt), 32'd1);
      check("single_rsp0_ovf", 32'(rsp0_ovf), 32'd0);

      // Mid-cycle asynchronous reset clears the slot without a clock edge
      reset = 1'b1;
      #1;
      check("async_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      check("async_rst_rsp0_result", rsp0_result, 32'd0);
      check("async_rst_rsp0_ne", 32'(rsp0_ne), 32'd0);
      driveStep();
      reset = 1'b0;

      // Contention: grants alternate starting with req0 after reset
      req0_valid = 1'b1; req0_opcode = 5'd1; req0_shamt = 5'd0; req0_a = 32'd3; req0_b = 32'd3;
      req1_valid = 1'b1; req1_opcode = 5'd2; req1_shamt = 5'd7; req1_a = 32'hF0; req1_b = 32'h3C;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check($sformatf("cont_req0_ready_%0d", i), 32'(req0_ready), 32'((i % 2) == 0));
         check($sformatf("cont_req1_ready_%0d", i), 32'(req1_ready), 32'((i % 2) == 1));
         if (i == 1) begin
            check("cont_alu_shamt", 32'(alu_shamt), 32'd7);
            check("cont_rsp0_valid", 32'(rsp0_valid), 32'd1);
            check("cont_rsp0_result", rsp0_result, 32'd0);
            check("cont_rsp0_ne", 32'(rsp0_ne), 32'd0);
         end
         if (i == 2) begin
            check("cont_rsp1_valid", 32'(rsp1_valid), 32'd1);
            check("cont_rsp1_result", rsp1_result, 32'h30);
            check("cont_rsp0_drained", 32'(rsp0_valid), 32'd0);
         end
         driveStep();
      end

      // Backpressure: slot 1 full from the last grant, rsp1_ready low
      rsp1_ready = 1'b0;
      req1_opcode = 5'd0; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1;
      req0_opcode = 5'd0; req0_a = 32'd5; req0_b = 32'd7;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         check($sformatf("bp_req1_ready_%0d", i), 32'(req1_ready), 32'd0);
         check($sformatf("bp_req0_ready_%0d", i), 32'(req0_ready), 32'd1);
         check($sformatf("bp_rsp1_valid_%0d", i), 32'(rsp1_valid), 32'd1);
         check($sformatf("bp_rsp1_result_%0d", i), rsp1_result, 32'h30);
         driveStep();
      end
      rsp1_ready = 1'b1;
      #1;
      check("bp_release_req1_ready", 32'(req1_ready), 32'd1);
      check("bp_release_req0_ready", 32'(req0_ready), 32'd0);
      check("bp_release_alu_opA", alu_opA, 32'h7FFF_FFFF);
      driveStep();
      req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      @(negedge clock);
      check("ovf_rsp1_valid", 32'(rsp1_valid), 32'd1);
      check("ovf_rsp1_result", rsp1_result, 32'h8000_0000);
      check("ovf_rsp1_ovf", 32'(rsp1_ovf), 32'd1);
      check("ovf_rsp1_lt", 32'(rsp1_lt), 32'd0);
      check("ovf_rsp1_ne", 32'(rsp1_ne), 32'd1);

      // Idle for 3 cycles: zero ALU inputs, slots hold
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check($sformatf("idle_alu_opA_%0d", i), alu_opA, 32'd0);
         check($sformatf("idle_alu_opB_%0d", i), alu_opB, 32'd0);
         check($sformatf("idle_alu_ctl_%0d", i), 32'({alu_opcode, alu_shamt}), 32'd0);
         check($sformatf("idle_rsp1_result_%0d", i), rsp1_result, 32'h8000_0000);
         check($sformatf("idle_rsp1_valid_%0d", i), 32'(rsp1_valid), 32'd1);
         driveStep();
      end

      // Pointer held at req0 across idle: contested grant goes to req0
      req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #1;
      check("post_idle_req0_ready", 32'(req0_ready), 32'd1);
      check("post_idle_req1_ready", 32'(req1_ready), 32'd0);
      driveStep();
      req0_valid = 1'b0; req1_valid = 1'b0;
      driveStep();

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Lets two requesters share one combinational ALU instance. Typical requesters are the execute stage on port 0 and the multdiv sequencer on port 1.
- Arbitrates round-robin each cycle, drives the ALU operand/opcode/shamt inputs from the winner, and captures the ALU outputs into a per-requester response register.
- Each request/response pair uses a valid/ready handshake, with one buffered response slot per requester.
- The ALU sits outside this block; this block only sequences and routes it.

Parameters:
- WIDTH, 32, data width of operands and result.
- OPW, 5, width of the opcode and of the shift amount.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 granted this cycle; transfer happens when valid&ready
- req0_opcode  in  OPW  ALU opcode for requester 0
- req0_shamt  in  OPW  shift amount for requester 0
- req0_a, req0_b  in  WIDTH  operands for requester 0
- req1_valid, req1_ready, req1_opcode, req1_shamt, req1_a, req1_b  same as port 0, for requester 1
- alu_opA, alu_opB  out  WIDTH  to the ALU operand inputs
- alu_opcode, alu_shamt  out  OPW  to the ALU control inputs
- alu_result  in  WIDTH  from the ALU
- alu_ne, alu_lt, alu_ovf  in  1  ALU isNotEqual, isLessThan, overflow
- rsp0_valid  out  1  response slot 0 holds a result
- rsp0_ready  in  1  requester 0 consumes the response
- rsp0_result  out  WIDTH  captured result
- rsp0_ne, rsp0_lt, rsp0_ovf  out  1  captured flags
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_ne, rsp1_lt, rsp1_ovf  same as slot 0, for requester 1

Behaviour:
- Reset (async, immediate):
  - rspX_valid=0 and rspX_result/flags=0.
  - Priority pointer ptr=0, so requester 0 is favoured first.
  - Any in-flight operation is discarded; there is no replay after reset deasserts.
- Eligibility: reqX is eligible when reqX_valid=1 AND (rspX_valid=0 OR rspX_ready=1). A full slot that is draining in the same cycle counts as free.
- Grant (combinational, at most one per cycle):
  - Both eligible: grant reqPTR.
  - One eligible: grant that one.
  - None eligible: no grant.
- reqX_ready = grantX. Ready may depend on valid.
- Requesters hold opcode/shamt/a/b stable while valid=1 and ready=0; a request is never withdrawn before grant.
- ALU drive:
  - On grant: alu_* = granted requester's fields.
  - With no grant: alu_opA=alu_opB=0, alu_opcode=0, alu_shamt=0. This gives deterministic, toggle-free idle inputs.
- Capture at the rising edge after grantX: rspX_result/ne/lt/ovf <= alu_*, and rspX_valid <= 1.
  - Latency is one cycle: a grant in cycle N gives rspX_valid=1 in cycle N+1.
- Slot update:
  - Capture and drain in the same cycle: load new data, rspX_valid stays 1.
  - Drain only: rspX_valid <= 0; data may be left stale.
  - rspX_valid=1 with rspX_ready=0: slot holds all fields stable.
- Pointer: after any grant, ptr <= the other requester. With no grant, ptr is unchanged. Each requester is therefore served at least every second grant.
- Throughput: each requester can sustain one op per cycle when its rsp_ready=1. Total throughput is one op per cycle.
- Opcode is not decoded; every opcode passes through unchanged, including unused values. Flags are captured raw regardless of opcode.
- There are no combinational paths from alu_* inputs to any output other than through registers.

Test Plan:
- Reset: assert reset mid-cycle with rsp0_valid=1 -> rsp0_valid=0 and rsp0_result=0 immediately, without waiting for a clock edge; ptr=0, so the first contested grant goes to req0.
- Single op: req0 with opcode=00000, a=5, b=7, rsp0_ready=1 -> req0_ready=1 and alu_opA=5 in cycle N; in cycle N+1 rsp0_valid=1, rsp0_result=12, ne=1, ovf=0.
- Contention: both valid every cycle, both rsp_ready=1, req0 doing sub 3-3 and req1 doing and 0xF0&0x3C -> grants alternate 0,1,0,1; rsp0 shows result 0 with ne=0; rsp1 shows 0x30.
- Backpressure: rsp1_ready=0 with a full slot and req1_valid=1 -> req1_ready=0 and slot 1 is stable; req0 is still granted each cycle; raise rsp1_ready -> req1 is granted that same cycle, and the new data replaces the old with rsp1_valid held at 1.
- Overflow pass-through: req1 add a=0x7FFFFFFF, b=1 -> rsp1_result=0x80000000, ovf=1, lt=0 (ALU flag captured raw).
- Idle: no valid for 3 cycles -> alu_* all 0, ptr unchanged, rsp slots unchanged.
